// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
package debounce_pkg;

    localparam int unsigned DEFAULT_STABLE_CYCLES = 8;

    // $clog2 yields 0 for n <= 1, but a counter needs at least one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced channel: 2-FF synchroniser, stability counter, registered edge pulses.
// Optional per-channel glitch counter when DEBOUNCE_GLITCH_CNT_EN is defined.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter logic        RESET_VAL     = 1'b1
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    parameter int unsigned GLITCH_W      = 8
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din,
`ifdef DEBOUNCE_GLITCH_CNT_EN
    input  logic                glitch_clr,
    output logic [GLITCH_W-1:0] glitch_cnt,
`endif
    output logic                dout,
    output logic                rise,
    output logic                fall
);

    localparam int unsigned      CNT_W   = clog2_min1(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_q;
    logic             out_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            cnt_q   <= '0;
            out_q   <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Any sample matching the current output drops the run back to zero.
    always_comb begin
        cnt_d  = '0;
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync2_q != out_q) begin
            if (cnt_q == CNT_MAX) begin
                out_d  = sync2_q;
                rise_d = sync2_q;
                fall_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign dout = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic                abort;
    logic [GLITCH_W-1:0] gcnt_q;

    assign abort = (cnt_q != '0) && (sync2_q == out_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt_q <= '0;
        end else if (glitch_clr) begin
            gcnt_q <= '0;
        end else if (abort && (gcnt_q != '1)) begin
            gcnt_q <= gcnt_q + 1'b1;
        end
    end

    assign glitch_cnt = gcnt_q;
`endif

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel input debouncer (e.g. I2C SCL/SDA pads); one debounce_chan per line.
// Define DEBOUNCE_GLITCH_CNT_EN to add glitch_clr/glitch_cnt and per-channel abort counters.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned         CHANNELS      = 2,
    parameter int unsigned         STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter logic [CHANNELS-1:0] RESET_VAL     = {CHANNELS{1'b1}},
    parameter int unsigned         GLITCH_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          in,
`ifdef DEBOUNCE_GLITCH_CNT_EN
    input  logic                         glitch_clr,
    output logic [CHANNELS*GLITCH_W-1:0] glitch_cnt,
`endif
    output logic [CHANNELS-1:0]          out,
    output logic [CHANNELS-1:0]          rise,
    output logic [CHANNELS-1:0]          fall
);

    if (CHANNELS < 1 || STABLE_CYCLES < 1 || GLITCH_W < 1) begin : g_param_err
        $error("debounce_multi: CHANNELS, STABLE_CYCLES and GLITCH_W must all be >= 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .RESET_VAL    (RESET_VAL[i])
`ifdef DEBOUNCE_GLITCH_CNT_EN
            ,
            .GLITCH_W     (GLITCH_W)
`endif
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .din       (in[i]),
`ifdef DEBOUNCE_GLITCH_CNT_EN
            .glitch_clr(glitch_clr),
            .glitch_cnt(glitch_cnt[i*GLITCH_W +: GLITCH_W]),
`endif
            .dout      (out[i]),
            .rise      (rise[i]),
            .fall      (fall[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Randomised scoreboard bench for debounce_multi against a sliding-window reference model.
// Glitch-counter checks are active when DEBOUNCE_GLITCH_CNT_EN is defined.
module tb_debounce_multi;

    localparam int unsigned   CH = 2;
    localparam int unsigned   SC = 8;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    localparam int unsigned   GW = 2;
`else
    localparam int unsigned   GW = 8;
`endif
    localparam logic [CH-1:0] RV = 2'b11;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [CH-1:0]        in;
    logic [CH-1:0]        out;
    logic [CH-1:0]        rise;
    logic [CH-1:0]        fall;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic                 glitch_clr;
    logic [CH*GW-1:0]     glitch_cnt;
`endif

    always #5 clk = ~clk;

    debounce_multi #(
        .CHANNELS     (CH),
        .STABLE_CYCLES(SC),
        .RESET_VAL    (RV),
        .GLITCH_W     (GW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
`ifdef DEBOUNCE_GLITCH_CNT_EN
        .glitch_clr(glitch_clr),
        .glitch_cnt(glitch_cnt),
`endif
        .out       (out),
        .rise      (rise),
        .fall      (fall)
    );

    typedef struct {
        logic [CH-1:0]    out;
        logic [CH-1:0]    rise;
        logic [CH-1:0]    fall;
        logic [CH*GW-1:0] g;
    } exp_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    bit            started  = 1'b0;
    exp_t          exp_q[$];
    exp_t          pe;
    exp_t          me;

    // Reference model: in_hist holds inputs seen at the last two edges, s_hist the
    // samples seen since reset; an output flips once its last SC samples all disagree.
    logic [CH-1:0] in_hist[$];
    logic [CH-1:0] s_hist[$];
    logic [CH-1:0] m_out;
    logic [CH-1:0] m_rise;
    logic [CH-1:0] m_fall;
    int            m_g[CH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        in_hist.delete();
        in_hist.push_back(RV);
        in_hist.push_back(RV);
        s_hist.delete();
        m_out  = RV;
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < CH; i++) m_g[i] = 0;
    endtask

    task automatic model_step();
        logic [CH-1:0] s;
        int            n;
        s = in_hist.pop_front();
        in_hist.push_back(in);
        s_hist.push_back(s);
        if (s_hist.size() > SC + 1) void'(s_hist.pop_front());
        n      = s_hist.size();
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < CH; i++) begin
            bit flip;
            bit glitch;
            flip = (n >= SC);
            if (flip) begin
                for (int k = 0; k < SC; k++) begin
                    if (s_hist[n-1-k][i] == m_out[i]) flip = 1'b0;
                end
            end
            glitch = 1'b0;
            if (n >= 2) begin
                glitch = (s[i] == m_out[i]) && (s_hist[n-2][i] != m_out[i]);
            end
`ifdef DEBOUNCE_GLITCH_CNT_EN
            if (glitch_clr) m_g[i] = 0;
            else if (glitch && m_g[i] < (1 << GW) - 1) m_g[i]++;
`else
            if (glitch) m_g[i]++;
`endif
            if (flip) begin
                m_out[i]  = s[i];
                m_rise[i] = s[i];
                m_fall[i] = ~s[i];
            end
        end
    endtask

    always @(posedge rst) begin
        model_reset();
        exp_q.delete();
        started = 1'b1;
    end

    always @(posedge clk) begin
        if (started) begin
            if (rst) model_reset();
            else model_step();
            pe.out  = m_out;
            pe.rise = m_rise;
            pe.fall = m_fall;
            pe.g    = '0;
            for (int i = 0; i < CH; i++) pe.g[i*GW +: GW] = GW'(m_g[i]);
            exp_q.push_back(pe);
        end
    end

    // Monitor: one expectation per clock, compared half a cycle after the edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            check("sb_out", 64'(out), 64'(me.out));
            check("sb_rise", 64'(rise), 64'(me.rise));
            check("sb_fall", 64'(fall), 64'(me.fall));
            check("sb_rise_fall_excl", 64'(rise & fall), 64'(0));
`ifdef DEBOUNCE_GLITCH_CNT_EN
            check("sb_glitch_cnt", 64'(glitch_cnt), 64'(me.g));
`endif
        end
    end

    task automatic hold(input logic [CH-1:0] v, input int n);
        in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_rst(input int n);
        #2 rst = 1'b1;
        #1;
        check("rst_out", 64'(out), 64'(RV));
        check("rst_rise", 64'(rise), 64'(0));
        check("rst_fall", 64'(fall), 64'(0));
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("rst_glitch_cnt", 64'(glitch_cnt), 64'(0));
`endif
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0t, required < 500000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CH-1:0] v;
        int            len;
        rst = 1'b0;
        in  = 2'b00;
`ifdef DEBOUNCE_GLITCH_CNT_EN
        glitch_clr = 1'b0;
`endif
        pulse_rst(3);
        hold(2'b11, 12);

        // Latency: in[0] falls before edge E, out[0] falls at E+9.
        in = 2'b10;
        repeat (9) @(negedge clk);
        check("lat_before", 64'(out), 64'(2'b11));
        @(negedge clk);
        check("lat_out", 64'(out), 64'(2'b10));
        check("lat_fall", 64'(fall), 64'(2'b01));
        check("lat_rise", 64'(rise), 64'(2'b00));
        @(negedge clk);
        check("lat_pulse_width", 64'(fall), 64'(2'b00));
        hold(2'b10, 5);

        // Glitch: 7 low cycles rejected, 8 low cycles accepted.
        hold(2'b00, 7);
        hold(2'b10, 12);
        check("glitch_no_flip", 64'(out), 64'(2'b10));
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("glitch_cnt_ch1", 64'(glitch_cnt[2*GW-1:GW]), 64'(1));
`endif
        hold(2'b00, 8);
        hold(2'b10, 2);
        check("glitch_8_flips", 64'(out), 64'(2'b00));
        hold(2'b10, 12);

        // Simultaneous channel flips.
        hold(2'b11, 12);
        in = 2'b00;
        repeat (10) @(negedge clk);
        check("sim_fall", 64'(fall), 64'(2'b11));
        hold(2'b00, 10);
        in = 2'b11;
        repeat (10) @(negedge clk);
        check("sim_rise", 64'(rise), 64'(2'b11));
        check("sim_out", 64'(out), 64'(2'b11));
        hold(2'b11, 10);

        // Reset mid-count with the input held low.
        hold(2'b10, 5);
        pulse_rst(2);
        in = 2'b10;
        repeat (9) @(negedge clk);
        check("rstmid_before", 64'(out), 64'(2'b11));
        @(negedge clk);
        check("rstmid_out", 64'(out), 64'(2'b10));
        check("rstmid_fall", 64'(fall), 64'(2'b01));
        hold(2'b10, 4);

`ifdef DEBOUNCE_GLITCH_CNT_EN
        // Saturation of a 2-bit counter, then clear winning over an abort.
        hold(2'b11, 12);
        glitch_clr = 1'b1;
        hold(2'b11, 1);
        glitch_clr = 1'b0;
        for (int r = 0; r < 5; r++) begin
            hold(2'b10, 3);
            hold(2'b11, 4);
        end
        check("sat_glitch_cnt", 64'(glitch_cnt[GW-1:0]), 64'(3));
        hold(2'b10, 3);
        hold(2'b11, 2);
        glitch_clr = 1'b1;
        hold(2'b11, 1);
        glitch_clr = 1'b0;
        check("clr_over_abort", 64'(glitch_cnt[GW-1:0]), 64'(0));
        hold(2'b11, 4);
`endif

        // Random segments: mostly short runs (glitches), some long enough to flip.
        for (int seg = 0; seg < 150; seg++) begin
            v   = CH'($urandom);
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(SC, 3 * SC))
                                              : int'($urandom_range(1, SC));
            if (seg == 75) pulse_rst(int'($urandom_range(1, 3)));
`ifdef DEBOUNCE_GLITCH_CNT_EN
            if ($urandom_range(0, 19) == 0) begin
                glitch_clr = 1'b1;
                hold(v, 1);
                glitch_clr = 1'b0;
                len = len - 1;
            end
`endif
            hold(v, len);
        end
        hold(in, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised multi-channel input debouncer, the successor to the single-line 8-sample shift-register debouncer.
- Each channel has a 2-FF synchroniser followed by a stability counter. A channel's output changes only after the synchronised input has held a new value for STABLE_CYCLES consecutive clocks.
- Provides registered rise/fall pulses and a per-channel reset value.
- Sits between the I2C pads (SCL/SDA) or other slow external lines and the protocol logic.

Parameters:
- CHANNELS, 2, number of independent input lines (must be ≥1).
- STABLE_CYCLES, 8, consecutive differing synchronised samples required before the output flips (must be ≥1).
- RESET_VAL, {CHANNELS{1'b1}}, per-channel value loaded into the synchroniser and `out` at reset (I2C idle high).
- GLITCH_W, 8, width of each glitch counter (used only with DEBOUNCE_GLITCH_CNT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- in  in  CHANNELS  raw asynchronous inputs
- out  out  CHANNELS  debounced levels
- rise  out  CHANNELS  1-cycle pulse in the cycle `out[i]` goes 0→1
- fall  out  CHANNELS  1-cycle pulse in the cycle `out[i]` goes 1→0

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - rst is asynchronous and active-high.
- Reset values, applied immediately on rst assertion:
  - sync1 = RESET_VAL, sync2 = RESET_VAL.
  - out = RESET_VAL.
  - cnt = 0.
  - rise = 0, fall = 0.
  - Glitch counters = 0.
- Synchroniser, per channel i:
  - sync1 <= in[i]; sync2 <= sync1.
  - The sampled value s = sync2.
- Counter:
  - cnt is unsigned, CNT_W = $clog2(STABLE_CYCLES) bits (minimum 1).
- Per-clock update, per channel, in priority order:
  - If s == out[i]: cnt <= 0; rise/fall <= 0.
  - Else if cnt == STABLE_CYCLES-1: out[i] <= s; cnt <= 0; rise[i] <= s; fall[i] <= ~s.
  - Else: cnt <= cnt+1; rise/fall <= 0.
- Latency:
  - in changes and is held stable from edge E, its first sampling edge.
  - s shows the new value after edge E+1.
  - out, and the rise or fall pulse, update at edge E+STABLE_CYCLES+1.
- Boundary conditions:
  - Glitch: any return of s to out[i] before the count completes clears cnt. No output change, no pulse, and the count restarts from 0 on the next difference.
  - STABLE_CYCLES = 1: out follows s one clock later; cnt stays 0.
  - cnt never exceeds STABLE_CYCLES-1. No wrap.
  - rise and fall are never both high on the same channel.
  - Each pulse lasts exactly one cycle. A back-to-back flip is impossible because it needs at least STABLE_CYCLES cycles.
- Channels are fully independent. Simultaneous changes on several channels flip their outputs on the same edge.
- Reset mid-count: the count is discarded. out returns to RESET_VAL even if the input is held at the opposite level. After release, out flips STABLE_CYCLES+1 edges after the first post-reset edge.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - Adds input port glitch_clr (1 bit) and output port glitch_cnt (CHANNELS*GLITCH_W bits, channel i at [i*GLITCH_W +: GLITCH_W]).
  - A channel's counter increments by 1 when cnt != 0 and s == out[i] in the same cycle, i.e. an aborted run.
  - It saturates at 2^GLITCH_W-1.
  - glitch_clr zeroes all counters synchronously and has priority over an increment in the same cycle.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Package debounce_pkg holds:
  - the function clog2_min1(n), used for CNT_W;
  - the localparam default DEFAULT_STABLE_CYCLES = 8.
- Sub-module debounce_chan: one channel (synchroniser, counter, out/rise/fall, optional glitch counter).
  - debounce_multi instantiates it CHANNELS times in a generate loop, with RESET_VAL[i] passed per instance.

Test Plan:
- Reset values: CHANNELS=2, RESET_VAL=2'b11, STABLE_CYCLES=8. Assert rst mid-cycle with in=2'b00 → out=2'b11, rise=fall=0 immediately (asynchronous), held while rst is high.
- Latency: after reset, in[0] 1→0 before edge E, held → out[0] falls at edge E+9; fall[0]=1 for exactly that cycle; out[1], rise and fall unchanged.
- Glitch rejection: in[1] low for 7 cycles, then high → out[1] stays 1, no pulse. With DEBOUNCE_GLITCH_CNT_EN, glitch_cnt[1]=1. A low of 8 cycles then flips out[1].
- Simultaneous channels: in=2'b00 at the same edge, then in=2'b11 after 20 cycles → both outs fall on the same edge and later rise on the same edge; rise=2'b11 for one cycle.
- Reset mid-count: in[0]=0 for 5 cycles, pulse rst, in held at 0 → out[0]=1 after reset, then falls 9 edges after the first post-reset edge.
- Saturation (macro on, GLITCH_W=2): 5 aborted runs → glitch_cnt=3. glitch_clr together with an abort edge → 0.
